// File: rtl/pc_ctrl.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with conditional
// absolute or PC-relative branching and a saturating retired-instruction count.
module pc_ctrl #(
    parameter int PW = 10,
    parameter int OW = 8
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          Branch,
    input  logic [1:0]    BrCond,
    input  logic          BrRel,
    input  logic [OW-1:0] Offset,
    input  logic [PW-1:0] Target,
    input  logic [2:0]    Flags,
    output logic [PW-1:0] PC,
    output logic          BrTaken,
    output logic          Running,
    output logic          Done,
    output logic [15:0]   InstCount
);

    // state   | meaning
    // S_IDLE  | waiting for Start after reset, PC held
    // S_RUN   | executing; PC advances or branches every cycle
    // S_HALTED| stopped by Halt; PC/count frozen until Start
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [15:0]   inst_count_q, inst_count_d;
    logic          br_taken_q, br_taken_d;

    logic          cond;
    logic          taken;
    logic [PW-1:0] offset_ext;

    assign offset_ext = PW'($signed(Offset));

    always_comb begin
        cond = 1'b1;
        unique case (BrCond)
            2'b00: cond = 1'b1;
            2'b01: cond = Flags[1];
            2'b10: cond = Flags[0];
            2'b11: cond = Flags[2];
            default: cond = 1'b1;
        endcase
    end

    assign taken = Branch & cond;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            inst_count_q <= '0;
            br_taken_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_count_q <= inst_count_d;
            br_taken_q   <= br_taken_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_count_d = inst_count_q;
        br_taken_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d      = S_RUN;
                    pc_d         = '0;
                    inst_count_d = '0;
                end
            end
            S_RUN: begin
                // Halt wins over any branch issued in the same cycle
                if (Halt) begin
                    state_d = S_HALTED;
                end else begin
                    if (inst_count_q != 16'hFFFF) begin
                        inst_count_d = inst_count_q + 16'd1;
                    end
                    if (taken) begin
                        pc_d       = BrRel ? (pc_q + offset_ext) : Target;
                        br_taken_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign PC        = pc_q;
    assign BrTaken   = br_taken_q;
    assign InstCount = inst_count_q;
    assign Running   = (state_q == S_RUN);
    assign Done      = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: per-cycle vector table plus hand sequences for
// count saturation and reset having no effect between clock edges.
module tb_pc_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic        Start, Halt, Branch, BrRel;
    logic [1:0]  BrCond;
    logic [7:0]  Offset;
    logic [9:0]  Target;
    logic [2:0]  Flags;
    logic [9:0]  PC;
    logic        BrTaken, Running, Done;
    logic [15:0] InstCount;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pc_ctrl #(.PW(10), .OW(8)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Halt(Halt), .Branch(Branch),
        .BrCond(BrCond), .BrRel(BrRel), .Offset(Offset), .Target(Target),
        .Flags(Flags), .PC(PC), .BrTaken(BrTaken), .Running(Running),
        .Done(Done), .InstCount(InstCount)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        hl;
        logic        br;
        logic [1:0]  cond;
        logic        rel;
        logic [7:0]  off;
        logic [9:0]  tgt;
        logic [2:0]  fl;
        logic [9:0]  e_pc;
        logic        e_bt;
        logic        e_run;
        logic        e_done;
        logic [15:0] e_ic;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset  = v.rst;
        Start  = v.st;
        Halt   = v.hl;
        Branch = v.br;
        BrCond = v.cond;
        BrRel  = v.rel;
        Offset = v.off;
        Target = v.tgt;
        Flags  = v.fl;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; Start = 1'b0; Halt = 1'b0; Branch = 1'b0;
        BrCond = 2'b00; BrRel = 1'b0; Offset = 8'h00; Target = 10'h000; Flags = 3'b000;
    endtask

    initial begin
        //               rst   st    hl    br    cond   rel   off    tgt      fl       pc      bt    run   done  ic
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd1,  1'b0, 1'b1, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd2,  1'b0, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd3,  1'b0, 1'b1, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd4,  1'b0, 1'b1, 1'b0, 16'd4});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd5,  1'b0, 1'b1, 1'b0, 16'd5});
        // jump to 20, then relative -4 taken on equal
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd20,  3'b000,  10'd20, 1'b1, 1'b1, 1'b0, 16'd6});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'hFC, 10'd0,   3'b010,  10'd16, 1'b1, 1'b1, 1'b0, 16'd7});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd20,  3'b000,  10'd20, 1'b1, 1'b1, 1'b0, 16'd8});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'hFC, 10'd0,   3'b000,  10'd21, 1'b0, 1'b1, 1'b0, 16'd9});
        // absolute to top of range, then wrap
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd100, 3'b000,  10'd100, 1'b1, 1'b1, 1'b0, 16'd10});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'h3FF, 3'b000,  10'd1023, 1'b1, 1'b1, 1'b0, 16'd11});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b1, 1'b0, 16'd12});
        // halt beats a taken branch; halt ignored while halted; restart
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd50,  3'b000,  10'd50, 1'b1, 1'b1, 1'b0, 16'd13});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 10'd7,   3'b000,  10'd50, 1'b0, 1'b0, 1'b1, 16'd13});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 10'd7,   3'b000,  10'd50, 1'b0, 1'b0, 1'b1, 16'd13});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b1, 1'b0, 16'd0});
        // greater and zero conditions
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 10'd5,   3'b001,  10'd5,  1'b1, 1'b1, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 8'h03, 10'd0,   3'b011,  10'd6,  1'b0, 1'b1, 1'b0, 16'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 8'h03, 10'd0,   3'b100,  10'd9,  1'b1, 1'b1, 1'b0, 16'd3});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd10, 1'b0, 1'b1, 1'b0, 16'd4});
        // reset mid-run at PC=37 with Start and Branch held
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd37,  3'b000,  10'd37, 1'b1, 1'b1, 1'b0, 16'd5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd9,   3'b000,  10'd0,  1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 10'd9,   3'b000,  10'd0,  1'b0, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 10'd0,   3'b000,  10'd0,  1'b0, 1'b1, 1'b0, 16'd0});
        // relative -128 from 0 wraps to 896
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h80, 10'd0,   3'b000,  10'd896, 1'b1, 1'b1, 1'b0, 16'd1});

        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge Clk);
            #1;
            chk("pc",      i, 16'(PC),        16'(vecs[i].e_pc));
            chk("brtaken", i, 16'(BrTaken),   16'(vecs[i].e_bt));
            chk("running", i, 16'(Running),   16'(vecs[i].e_run));
            chk("done",    i, 16'(Done),      16'(vecs[i].e_done));
            chk("icount",  i, InstCount,      vecs[i].e_ic);
        end

        // saturation: halt, restart, then run 65534 cycles to reach FFFE
        idle_inputs();
        Halt = 1'b1;
        @(posedge Clk); #1;
        chk("sat_halted", 0, 16'(Done), 16'd1);
        Halt  = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        chk("sat_restart_ic", 0, InstCount, 16'd0);
        Start = 1'b0;
        repeat (65534) @(posedge Clk);
        #1;
        chk("sat_fffe", 0, InstCount, 16'hFFFE);
        for (int k = 1; k <= 3; k++) begin
            @(posedge Clk); #1;
            chk("sat_ffff", k, InstCount, 16'hFFFF);
        end
        // 65537 increments from 0 modulo 1024
        chk("sat_pc", 0, 16'(PC), 16'd1);

        // reset between edges must not disturb outputs
        #1;
        reset = 1'b0;
        #2;
        chk("rst_sync_pc",  0, 16'(PC),      16'd1);
        chk("rst_sync_run", 0, 16'(Running), 16'd1);
        @(posedge Clk); #1;
        chk("rst_edge_pc",  0, 16'(PC),      16'd0);
        chk("rst_edge_run", 0, 16'(Running), 16'd0);
        chk("rst_edge_ic",  0, InstCount,    16'd0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
